cw_enc_stream: RTL and testbench
================================

CW_ENC_STREAM -- requirements
Module: cw_enc_stream

Interface
REQ-001 Parameters SHALL be (name, default, meaning): IN_W, 8, message word width; IN_DEPTH, 16, input FIFO depth in words (power of 2, >=2); CW_W, 11, codeword width; OUT_DEPTH, 4, output FIFO depth in codewords (power of 2, >=2); CW_PER_MSG, 10, codewords per message; MSB_FIRST, 1, serialisation order (1 = bit IN_W-1 first, 0 = bit 0 first).
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock, all logic on its rising edge.
- rst_b, in, 1, reset, synchronous and active-low.
- start, in, 1, one-cycle message start pulse.
- msg_byte, in, IN_W, message word to be written.
- wr_en, in, 1, write strobe for msg_byte.
- wr_full, out, 1, input FIFO full.
- wr_count, out, clog2(IN_DEPTH)+1, words held in input FIFO.
- core_start, out, 1, start pulse to encoder core.
- core_bit, out, 1, current message bit to core.
- core_empty, out, 1, no message bit available.
- core_rd, in, 1, core consumes core_bit.
- core_cw, in, CW_W, codeword from core.
- core_rdy, in, 1, core_cw valid this cycle.
- core_done, in, 1, core finished message.
- cw_out, out, CW_W, head codeword of output FIFO.
- cw_valid, out, 1, cw_out valid.
- cw_ready, in, 1, downstream accepts cw_out.
- cw_last, out, 1, cw_out is final codeword of message.
- cw_done, out, 1, one-cycle message-complete pulse.
- busy, out, 1, state not IDLE.
- err, out, 2, sticky: [0] output overflow, [1] codeword count mismatch.

Function
REQ-003 Input FIFO SHALL write msg_byte when wr_en && !wr_full; wr_en while full SHALL be dropped with no state change.
REQ-004 Serialiser SHALL hold a shift register and bit counter (0..IN_W); core_empty SHALL equal (bit counter == 0); core_bit SHALL be the next bit in MSB_FIRST order, 0 when empty.
REQ-005 When bit counter == 0 and input FIFO non-empty, serialiser SHALL load the head word next cycle (counter = IN_W).
REQ-006 core_rd while core_empty SHALL be ignored; core_rd while !core_empty SHALL advance one bit per cycle.
REQ-007 core_rd on the last bit (counter == 1) with input FIFO non-empty SHALL reload in the same cycle, giving gapless bits.
REQ-008 Simultaneous write to an empty input FIFO and load attempt SHALL not forward; the word becomes loadable the following cycle.
REQ-009 FSM states SHALL be IDLE, RUN, DRAIN. IDLE->RUN on start (core_start asserted exactly one cycle, the cycle after start; err and codeword counter cleared). RUN->DRAIN on core_done. DRAIN->IDLE when output FIFO empty; cw_done pulses one cycle on that transition.
REQ-010 start outside IDLE SHALL be ignored; core_rdy and core_done in IDLE SHALL be ignored.
REQ-011 In RUN, core_rdy SHALL push core_cw into the output FIFO with a last tag set when it is the CW_PER_MSG-th codeword; counter increments per core_rdy.
REQ-012 core_rdy with output FIFO full (and no pop same cycle) SHALL drop the codeword and set err[0]; push with simultaneous pop on full SHALL succeed.
REQ-013 core_done with codeword count != CW_PER_MSG SHALL set err[1]; count beyond CW_PER_MSG SHALL set err[1] and those words carry no last tag.
REQ-014 Output side SHALL be valid/ready: pop when cw_valid && cw_ready; cw_out and cw_last SHALL hold stable while cw_valid && !cw_ready.
REQ-015 core_done and core_rdy in the same cycle SHALL process the codeword first, then transition to DRAIN.

Reset
REQ-016 rst_b low at a clock edge SHALL empty both FIFOs, clear serialiser, counters, err, enter IDLE; all outputs 0 (wr_count 0, core_empty 1) the following cycle, including mid-message.

Verification
REQ-017 Write 0xA5 with defaults, core_rd held high -> core_bit sequence 1,0,1,0,0,1,0,1 then core_empty=1; MSB_FIRST=0 -> 1,0,1,0,0,1,0,1 reversed (1,0,1,0,0,1,0,1 for 0xA5 is palindromic; also check 0x01 -> 1 first then 0s).
REQ-018 Write 16 words then a 17th -> wr_full=1, wr_count=16, 17th dropped; two back-to-back words serialise 16 bits with no core_empty gap.
REQ-019 start, model core returns 10 codewords then core_done, cw_ready=1 -> 10 cw_out in order, cw_last only on 10th, cw_done one cycle after last pop, err=0.
REQ-020 cw_ready=0, core returns 5 codewords with OUT_DEPTH=4 -> err[0]=1, first 4 delivered after cw_ready=1; core_done after 9 words -> err[1]=1.
REQ-021 rst_b low during RUN with both FIFOs non-empty -> next cycle busy=0, cw_valid=0, wr_count=0, core_empty=1, err=0.

Source files
------------

// File: rtl/cw_enc_stream.sv
// Streaming front-end for a codeword encoder core: buffers message words,
// serialises them bit by bit to the core, and collects the returned
// codewords into a valid/ready output FIFO tagged with an end-of-message flag.
//
// state   | meaning
// IDLE    | waiting for start; core handshakes ignored
// RUN     | message in progress; codewords pushed to output FIFO
// DRAIN   | core finished; waiting for output FIFO to empty
module cw_enc_stream #(
  parameter int IN_W       = 8,
  parameter int IN_DEPTH   = 16,
  parameter int CW_W       = 11,
  parameter int OUT_DEPTH  = 4,
  parameter int CW_PER_MSG = 10,
  parameter int MSB_FIRST  = 1
) (
  input  logic                        clk,
  input  logic                        rst_b,
  input  logic                        start,
  input  logic [IN_W-1:0]             msg_byte,
  input  logic                        wr_en,
  output logic                        wr_full,
  output logic [$clog2(IN_DEPTH):0]   wr_count,
  output logic                        core_start,
  output logic                        core_bit,
  output logic                        core_empty,
  input  logic                        core_rd,
  input  logic [CW_W-1:0]             core_cw,
  input  logic                        core_rdy,
  input  logic                        core_done,
  output logic [CW_W-1:0]             cw_out,
  output logic                        cw_valid,
  input  logic                        cw_ready,
  output logic                        cw_last,
  output logic                        cw_done,
  output logic                        busy,
  output logic [1:0]                  err
);

  localparam int IAW = $clog2(IN_DEPTH);
  localparam int OAW = $clog2(OUT_DEPTH);
  localparam int BCW = $clog2(IN_W + 1);
  localparam int CCW = $clog2(CW_PER_MSG + 1) + 1;
  localparam logic [IAW:0] IN_FULL  = (IAW+1)'(IN_DEPTH);
  localparam logic [OAW:0] OUT_FULL = (OAW+1)'(OUT_DEPTH);
  localparam logic [CCW-1:0] CPM    = CCW'(CW_PER_MSG);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t          state_q, state_d;
  logic [IN_W-1:0] in_mem [IN_DEPTH];
  logic [IAW-1:0]  in_wp_q, in_wp_d, in_rp_q, in_rp_d;
  logic [IAW:0]    in_cnt_q, in_cnt_d;
  logic [IN_W-1:0] sh_q, sh_d;
  logic [BCW-1:0]  bcnt_q, bcnt_d;
  logic [CW_W:0]   out_mem [OUT_DEPTH];
  logic [OAW-1:0]  out_wp_q, out_wp_d, out_rp_q, out_rp_d;
  logic [OAW:0]    out_cnt_q, out_cnt_d;
  logic [CCW-1:0]  cw_cnt_q, cw_cnt_d, cnt_inc;
  logic [1:0]      err_q, err_d;
  logic            core_start_q, core_start_d;
  logic            in_push, ser_empty, ser_adv, ser_load;
  logic            rdy_run, out_push, out_pop, push_last;
  logic [CW_W:0]   out_head;

  // Input FIFO and bit serialiser; loads only from words already stored.
  always_comb begin
    in_push   = wr_en && (in_cnt_q != IN_FULL);
    ser_empty = (bcnt_q == '0);
    ser_adv   = core_rd && !ser_empty;
    ser_load  = (in_cnt_q != '0) && (ser_empty || (ser_adv && bcnt_q == BCW'(1)));
    in_wp_d   = in_push  ? in_wp_q + 1'b1 : in_wp_q;
    in_rp_d   = ser_load ? in_rp_q + 1'b1 : in_rp_q;
    in_cnt_d  = in_cnt_q + {{IAW{1'b0}}, in_push} - {{IAW{1'b0}}, ser_load};
    sh_d      = sh_q;
    bcnt_d    = bcnt_q;
    if (ser_load) begin
      sh_d   = in_mem[in_rp_q];
      bcnt_d = BCW'(IN_W);
    end else if (ser_adv) begin
      sh_d   = (MSB_FIRST != 0) ? {sh_q[IN_W-2:0], 1'b0} : {1'b0, sh_q[IN_W-1:1]};
      bcnt_d = bcnt_q - 1'b1;
    end
  end

  // Sequencer FSM and output FIFO bookkeeping.
  always_comb begin
    state_d      = state_q;
    cw_cnt_d     = cw_cnt_q;
    err_d        = err_q;
    core_start_d = 1'b0;
    cw_done      = 1'b0;
    cnt_inc      = (cw_cnt_q == '1) ? cw_cnt_q : cw_cnt_q + 1'b1;
    out_pop      = (out_cnt_q != '0) && cw_ready;
    rdy_run      = (state_q == S_RUN) && core_rdy;
    out_push     = rdy_run && ((out_cnt_q != OUT_FULL) || out_pop);
    push_last    = (cnt_inc == CPM);
    if (rdy_run) begin
      cw_cnt_d = cnt_inc;
      if (!out_push) err_d[0] = 1'b1;
      if (cnt_inc > CPM) err_d[1] = 1'b1;
    end
    case (state_q)
      S_IDLE: if (start) begin
        state_d      = S_RUN;
        core_start_d = 1'b1;
        err_d        = 2'b00;
        cw_cnt_d     = '0;
      end
      S_RUN: if (core_done) begin
        state_d = S_DRAIN;
        if (cw_cnt_d != CPM) err_d[1] = 1'b1;
      end
      S_DRAIN: if (out_cnt_q == '0) begin
        state_d = S_IDLE;
        cw_done = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    out_wp_d  = out_push ? out_wp_q + 1'b1 : out_wp_q;
    out_rp_d  = out_pop  ? out_rp_q + 1'b1 : out_rp_q;
    out_cnt_d = out_cnt_q + {{OAW{1'b0}}, out_push} - {{OAW{1'b0}}, out_pop};
  end

  // Output drive; data outputs forced low when nothing is held.
  always_comb begin
    out_head   = out_mem[out_rp_q];
    cw_valid   = (out_cnt_q != '0);
    cw_out     = cw_valid ? out_head[CW_W-1:0] : '0;
    cw_last    = cw_valid && out_head[CW_W];
    wr_full    = (in_cnt_q == IN_FULL);
    wr_count   = in_cnt_q;
    core_empty = ser_empty;
    core_bit   = ser_empty ? 1'b0 : ((MSB_FIRST != 0) ? sh_q[IN_W-1] : sh_q[0]);
    core_start = core_start_q;
    busy       = (state_q != S_IDLE);
    err        = err_q;
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (in_push)  in_mem[in_wp_q]   <= msg_byte;
    if (out_push) out_mem[out_wp_q] <= {push_last, core_cw};
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q      <= S_IDLE;
      in_wp_q      <= '0;
      in_rp_q      <= '0;
      in_cnt_q     <= '0;
      sh_q         <= '0;
      bcnt_q       <= '0;
      out_wp_q     <= '0;
      out_rp_q     <= '0;
      out_cnt_q    <= '0;
      cw_cnt_q     <= '0;
      err_q        <= '0;
      core_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_wp_q      <= in_wp_d;
      in_rp_q      <= in_rp_d;
      in_cnt_q     <= in_cnt_d;
      sh_q         <= sh_d;
      bcnt_q       <= bcnt_d;
      out_wp_q     <= out_wp_d;
      out_rp_q     <= out_rp_d;
      out_cnt_q    <= out_cnt_d;
      cw_cnt_q     <= cw_cnt_d;
      err_q        <= err_d;
      core_start_q <= core_start_d;
    end
  end

endmodule

// File: tb/tb_cw_enc_stream.sv
// Directed bench for cw_enc_stream: bit-order, FIFO-full, message flow,
// overflow/count errors and mid-message reset, with queue scoreboards.
module tb_cw_enc_stream;

  logic        clk = 1'b0;
  logic        rst_b, start, wr_en, core_rd, core_rdy, core_done, cw_ready;
  logic [7:0]  msg_byte;
  logic [10:0] core_cw;

  logic        wr_full, core_start, core_bit, core_empty, cw_valid, cw_last, cw_done, busy;
  logic [4:0]  wr_count;
  logic [10:0] cw_out;
  logic [1:0]  err;

  logic        wr_full_l, core_start_l, core_bit_l, core_empty_l, cw_valid_l, cw_last_l;
  logic        cw_done_l, busy_l;
  logic [4:0]  wr_count_l;
  logic [10:0] cw_out_l;
  logic [1:0]  err_l;

  int ncmp = 0, nfail = 0, cyc = 0, pop_cyc = -1, done_cyc = -1, done_n = 0;
  logic        bq[$];
  logic        lq[$];
  logic [11:0] cq[$];

  always #5 clk = ~clk;

  cw_enc_stream u_dut (
    .clk(clk), .rst_b(rst_b), .start(start), .msg_byte(msg_byte), .wr_en(wr_en),
    .wr_full(wr_full), .wr_count(wr_count), .core_start(core_start), .core_bit(core_bit),
    .core_empty(core_empty), .core_rd(core_rd), .core_cw(core_cw), .core_rdy(core_rdy),
    .core_done(core_done), .cw_out(cw_out), .cw_valid(cw_valid), .cw_ready(cw_ready),
    .cw_last(cw_last), .cw_done(cw_done), .busy(busy), .err(err)
  );

  cw_enc_stream #(.MSB_FIRST(0)) u_lsb (
    .clk(clk), .rst_b(rst_b), .start(start), .msg_byte(msg_byte), .wr_en(wr_en),
    .wr_full(wr_full_l), .wr_count(wr_count_l), .core_start(core_start_l), .core_bit(core_bit_l),
    .core_empty(core_empty_l), .core_rd(core_rd), .core_cw(core_cw), .core_rdy(core_rdy),
    .core_done(core_done), .cw_out(cw_out_l), .cw_valid(cw_valid_l), .cw_ready(cw_ready),
    .cw_last(cw_last_l), .cw_done(cw_done_l), .busy(busy_l), .err(err_l)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) bq.push_back(w[i]);
    for (int i = 0; i < 8; i++) lq.push_back(w[i]);
  endtask

  // Score what is consumed/popped at the coming edge, then advance one cycle.
  task automatic tick();
    logic [11:0] h;
    if (core_rd && !core_empty) begin
      chk("bit_expected", bq.size() != 0, 1);
      if (bq.size() != 0) chk("core_bit_msb", core_bit, bq.pop_front());
    end
    if (core_rd && !core_empty_l) begin
      chk("bit_expected_lsb", lq.size() != 0, 1);
      if (lq.size() != 0) chk("core_bit_lsb", core_bit_l, lq.pop_front());
    end
    if (cw_valid && cw_ready) begin
      chk("cw_expected", cq.size() != 0, 1);
      if (cq.size() != 0) begin
        h = cq.pop_front();
        chk("cw_out_last", {cw_last, cw_out}, h);
      end
      pop_cyc = cyc;
    end
    if (cw_done) begin
      done_cyc = cyc;
      done_n++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    logic started;
    rst_b = 1'b0; start = 1'b0; wr_en = 1'b0; core_rd = 1'b0; core_rdy = 1'b0;
    core_done = 1'b0; cw_ready = 1'b0; msg_byte = '0; core_cw = '0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_cw_valid", cw_valid, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_core_empty", core_empty, 1);
    chk("rst_err", err, 0);
    chk("rst_wr_full", wr_full, 0);
    chk("rst_core_start", core_start, 0);
    rst_b = 1'b1;
    tick();

    // Bit order for 0xA5 then 0x01, back to back with no empty gap.
    wr_en = 1'b1; msg_byte = 8'hA5; push_word(8'hA5); tick();
    msg_byte = 8'h01; push_word(8'h01); tick();
    wr_en = 1'b0; core_rd = 1'b1; started = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (!core_empty) started = 1'b1;
      if (started && bq.size() != 0) chk("no_gap", core_empty, 0);
      tick();
    end
    chk("bits_consumed", bq.size(), 0);
    chk("empty_after_bits", core_empty, 1);

    // Fill: one word parked in the serialiser, 16 in the FIFO, 17th dropped.
    core_rd = 1'b0;
    wr_en = 1'b1; msg_byte = 8'h3C; push_word(8'h3C); tick();
    for (int i = 0; i < 17; i++) begin
      msg_byte = 8'($urandom);
      if (i < 16) push_word(msg_byte);
      tick();
    end
    wr_en = 1'b0;
    chk("full_flag", wr_full, 1);
    chk("full_count", wr_count, 16);
    core_rd = 1'b1;
    for (int i = 0; i < 200 && bq.size() != 0; i++) tick();
    repeat (4) tick();
    chk("fill_bits_consumed", bq.size(), 0);
    chk("fill_empty", core_empty, 1);
    chk("fill_count_zero", wr_count, 0);
    core_rd = 1'b0;

    // Core handshakes in IDLE are ignored.
    core_rdy = 1'b1; core_done = 1'b1; core_cw = 11'h123; tick();
    core_rdy = 1'b0; core_done = 1'b0; tick();
    chk("idle_rdy_ignored", cw_valid, 0);
    chk("idle_busy", busy, 0);

    // Full message of 10 codewords with downstream always ready.
    done_n = 0;
    start = 1'b1; tick(); start = 1'b0;
    chk("core_start_pulse", core_start, 1);
    chk("busy_run", busy, 1);
    start = 1'b1; tick(); start = 1'b0;
    chk("core_start_once", core_start, 0);
    cw_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      core_rdy = 1'b1; core_cw = 11'($urandom);
      cq.push_back({(i == 9), core_cw});
      tick();
    end
    core_rdy = 1'b0; core_done = 1'b1; tick(); core_done = 1'b0;
    repeat (10) tick();
    chk("msg_all_popped", cq.size(), 0);
    chk("msg_done_count", done_n, 1);
    chk("msg_done_timing", done_cyc, pop_cyc + 1);
    chk("msg_err", err, 0);
    chk("msg_idle", busy, 0);

    // Overflow with stalled output, then 9-codeword message.
    cw_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0; tick();
    for (int i = 0; i < 5; i++) begin
      core_rdy = 1'b1; core_cw = 11'($urandom);
      if (i < 4) cq.push_back({1'b0, core_cw});
      tick();
    end
    core_rdy = 1'b0; tick();
    chk("ovf_err0", err, 2'b01);
    chk("ovf_valid", cw_valid, 1);
    tick();
    chk("ovf_hold", {cw_last, cw_out}, cq[0]);
    cw_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      core_rdy = 1'b1; core_cw = 11'($urandom);
      cq.push_back({1'b0, core_cw});
      tick();
    end
    core_rdy = 1'b0; core_done = 1'b1; tick(); core_done = 1'b0;
    repeat (10) tick();
    chk("ovf_all_popped", cq.size(), 0);
    chk("ovf_err_both", err, 2'b11);
    chk("ovf_idle", busy, 0);

    // Mid-message reset with both FIFOs holding data.
    cw_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    wr_en = 1'b1;
    for (int i = 0; i < 3; i++) begin msg_byte = 8'(i + 1); tick(); end
    wr_en = 1'b0;
    for (int i = 0; i < 5; i++) begin core_rdy = 1'b1; core_cw = 11'(i); tick(); end
    core_rdy = 1'b0;
    chk("pre_rst_count", wr_count, 2);
    chk("pre_rst_err", err, 2'b01);
    chk("pre_rst_valid", cw_valid, 1);
    rst_b = 1'b0; tick();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", cw_valid, 0);
    chk("mid_rst_count", wr_count, 0);
    chk("mid_rst_empty", core_empty, 1);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_cw_out", cw_out, 0);
    rst_b = 1'b1; tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
